wmem_stream_loader: RTL
=======================

Name: wmem_stream_loader

Overview:
- Upstream feeder for the PE-array wrapper's banked weight/activation memories (WQ/WK/WV/WF1/WF2/X/O).
- Accepts a load command, then a narrow valid/ready beat stream from the host/DMA side.
- Packs beats into full memory lines and issues one write per line on the wrapper's shared memory port: mem_sel, mem_en, mem_wr, mem_addr, mem_in.
- Pulses done when the commanded number of lines has been written.

Parameters:
- DATA_WIDTH, 8, element width
- NUM_PEs, 4, PEs per row
- NUM_MACS, 4, MACs per PE
- NUM_ROWS, 4, weight-memory partitions
- IN_WIDTH, 32, stream beat width; must divide X_LINE_W and W_LINE_W
- MEM_DEPTH, 4608, lines per memory (d*H*L)
- ADDR_W, 13, width(MEM_DEPTH); derived
- W_LINE_W, 512, DATA_WIDTH*NUM_MACS*NUM_PEs*NUM_ROWS; derived
- X_LINE_W, 32, DATA_WIDTH*NUM_PEs; derived

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  load command valid
- cmd_ready  out  1  high only in IDLE
- cmd_sel  in  3  target memory select, same encoding as wrapper mem_sel; 5 and 7 = X memory
- cmd_base  in  ADDR_W  first line address
- cmd_lines  in  ADDR_W+1  number of lines to write
- s_valid  in  1  beat valid
- s_ready  out  1  beat ready
- s_data  in  IN_WIDTH  beat payload
- mem_sel  out  3  registered cmd_sel, held for the whole load
- mem_en  out  1  memory enable, write cycle only
- mem_wr  out  1  write strobe, equal to mem_en
- mem_addr  out  ADDR_W  line address
- mem_in  out  W_LINE_W  packed line
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse at load end
- err  out  1  one-cycle pulse on rejected command

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State IDLE. Line buffer, beat counter and line counter are cleared.
- Beats per line: BPL = X_LINE_W/IN_WIDTH for sel 5/7; W_LINE_W/IN_WIDTH otherwise. Defaults give 1 and 16.
- States: IDLE, FILL, WRITE, FIN.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch sel, base, lines, BPL.
  - If lines==0 or base+lines > MEM_DEPTH (computed ADDR_W+2 bits wide, no wrap): pulse err next cycle, stay IDLE, no write.
  - Otherwise go to FILL with beat_cnt=0 and line_cnt=0.
- FILL:
  - s_ready=1. Each handshake stores s_data into buf[beat_cnt*IN_WIDTH +: IN_WIDTH] and increments beat_cnt.
  - On the handshake with beat_cnt==BPL-1, go to WRITE.
  - s_valid low stalls with no state change.
- WRITE (exactly one cycle):
  - mem_en=mem_wr=1, mem_addr=base+line_cnt, mem_in=buf.
  - For X sel, bits above X_LINE_W are 0.
  - s_ready=0 in this cycle.
  - If line_cnt==lines-1, go to FIN; else increment line_cnt, clear beat_cnt, return to FILL.
- FIN: done=1 for one cycle, then IDLE. cmd_ready returns to 1 the cycle after done.
- Latency and throughput:
  - The write appears the cycle after the last beat handshake.
  - Steady state is BPL+1 cycles per line.
  - Total load time is lines*(BPL+1)+1 cycles from the first beat, assuming no stalls.
- mem_en and mem_wr are 0 in every state except WRITE. mem_sel is stable from command accept until FIN.
- cmd_valid while busy is ignored (cmd_ready=0). Beats presented in IDLE or FIN are not accepted (s_ready=0).
- rst asserted mid-load: immediate return to reset values. The partial line is discarded and no write is issued. Lines already written remain in memory.
- All outputs are registered. No combinational path from s_valid to s_ready.

Decomposition:
- Shared package (e.g. vit_pkg):
  - mem_sel encoding constants: MEM_WQ=0, MEM_WK=1, MEM_WV=2, MEM_WF1=3, MEM_WF2=4, MEM_X=5, MEM_O=6, MEM_X_ALT=7.
  - Derived line-width constants.
  - The width() function.
- Sub-module: line_packer, holding the buffer, beat counter and last-beat flag with a BPL input. Top level holds the FSM and address logic.

Test Plan:
- WQ load, base=0, lines=2, 32 beats of values 0..31, no stalls:
  - two writes, at addr 0 and 1;
  - mem_in[31:0] = beat0 at addr 0 and = beat16 at addr 1;
  - done exactly 2*17+1 cycles after the first beat.
- X load (sel 5), base=100, lines=3, beats A,B,C:
  - writes to addr 100, 101, 102 with mem_in[31:0] = A, B, C;
  - mem_in[511:32] = 0;
  - each write follows its beat by 1 cycle.
- Random s_valid gaps (50%) on a WK load, base=7, lines=1:
  - a single write at addr 7 with correctly ordered packing;
  - no mem_en pulse before the 16th beat.
- Rejected commands:
  - lines=0 gives an err pulse and no mem_en;
  - base=4600, lines=10 gives an err pulse and no mem_en;
  - cmd_ready=1 again the following cycle.
- cmd_valid asserted during a WV load:
  - cmd_ready=0 and the second command is ignored;
  - mem_sel stays 2 until done.
- rst low after 9 beats of a WQ load: all outputs go to reset values asynchronously and no write occurs; a fresh command afterwards completes normally.

Source files
------------

// File: rtl/wmem_stream_loader_pkg.sv
// Shared definitions for the weight/activation memory stream loader:
// memory-select encoding, default geometry, loader states and helpers.
package wmem_stream_loader_pkg;

  // Memory select encoding shared with the PE-array wrapper's memory port.
  typedef enum logic [2:0] {
    MEM_WQ    = 3'd0,
    MEM_WK    = 3'd1,
    MEM_WV    = 3'd2,
    MEM_WF1   = 3'd3,
    MEM_WF2   = 3'd4,
    MEM_X     = 3'd5,
    MEM_O     = 3'd6,
    MEM_X_ALT = 3'd7
  } mem_sel_e;

  // Default array geometry and the line widths derived from it.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_PES    = 4;
  localparam int DEF_NUM_MACS   = 4;
  localparam int DEF_NUM_ROWS   = 4;
  localparam int DEF_IN_WIDTH   = 32;
  localparam int DEF_MEM_DEPTH  = 4608;
  localparam int DEF_W_LINE_W   = DEF_DATA_WIDTH * DEF_NUM_MACS * DEF_NUM_PES * DEF_NUM_ROWS;
  localparam int DEF_X_LINE_W   = DEF_DATA_WIDTH * DEF_NUM_PES;

  // Loader control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Number of bits needed to hold the value n (width(4608) = 13, width(16) = 5).
  function automatic int width(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if (n >= (1 << i)) w = i + 1;
    end
    return w;
  endfunction

  // Both X encodings address the narrow activation memory.
  function automatic logic is_x_sel(input logic [2:0] sel);
    return (sel == MEM_X) || (sel == MEM_X_ALT);
  endfunction

endpackage

// File: rtl/wmem_stream_loader_line_packer.sv
// Packs narrow stream beats into one memory line. Slot gi of the line is
// filled by the gi-th beat; the beat counter wraps after the last beat of a
// line so the next line starts at slot 0 without extra control.
module wmem_stream_loader_line_packer #(
  parameter int IN_WIDTH = 32,
  parameter int MAX_BPL  = 16,
  parameter int CNT_W    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         beat_i,
  input  logic [IN_WIDTH-1:0]          data_i,
  input  logic [CNT_W-1:0]             bpl_i,
  output logic [MAX_BPL*IN_WIDTH-1:0]  line_o,
  output logic                         last_o
);

  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] beat_cnt_d;

  assign last_o = (beat_cnt_q == bpl_i - CNT_W'(1));

  // Next beat slot: restart on a new load, wrap after the line's last beat.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (clear_i) begin
      beat_cnt_d = '0;
    end else if (beat_i) begin
      beat_cnt_d = last_o ? '0 : beat_cnt_q + CNT_W'(1);
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) beat_cnt_q <= '0;
    else      beat_cnt_q <= beat_cnt_d;
  end

  // One register slice per beat slot. Clearing the whole line at load start
  // keeps the unused upper slots at zero for narrow (X) lines.
  for (genvar gi = 0; gi < MAX_BPL; gi++) begin : g_slot
    logic [IN_WIDTH-1:0] slot_q;

    // Capture this slot's beat; a new load wipes it.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        slot_q <= '0;
      end else if (clear_i) begin
        slot_q <= '0;
      end else if (beat_i && (beat_cnt_q == CNT_W'(gi))) begin
        slot_q <= data_i;
      end
    end

    assign line_o[gi*IN_WIDTH +: IN_WIDTH] = slot_q;
  end

endmodule

// File: rtl/wmem_stream_loader.sv
// Streams narrow host/DMA beats into full memory lines and writes them through
// the wrapper's shared memory port, one write per packed line, then pulses done.
// All outputs come straight from registers; they are loaded from the next state.
module wmem_stream_loader
  import wmem_stream_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_PEs    = DEF_NUM_PES,
  parameter int NUM_MACS   = DEF_NUM_MACS,
  parameter int NUM_ROWS   = DEF_NUM_ROWS,
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int ADDR_W     = width(MEM_DEPTH),
  parameter int W_LINE_W   = DATA_WIDTH * NUM_MACS * NUM_PEs * NUM_ROWS,
  parameter int X_LINE_W   = DATA_WIDTH * NUM_PEs
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_sel,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [ADDR_W:0]     cmd_lines,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_WIDTH-1:0] s_data,
  output logic [2:0]          mem_sel,
  output logic                mem_en,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [W_LINE_W-1:0] mem_in,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int MAX_BPL = W_LINE_W / IN_WIDTH;
  localparam int X_BPL   = X_LINE_W / IN_WIDTH;
  localparam int CNT_W   = width(MAX_BPL);
  localparam int SUM_W   = ADDR_W + 2;
  localparam int LINES_W = ADDR_W + 1;

  state_e              state_q;
  state_e              state_d;
  logic [2:0]          sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINES_W-1:0]  lines_q;
  logic [LINES_W-1:0]  line_cnt_q;
  logic [CNT_W-1:0]    bpl_q;

  logic cmd_ready_q, cmd_ready_d;
  logic s_ready_q,   s_ready_d;
  logic mem_en_q,    mem_en_d;
  logic busy_q,      busy_d;
  logic done_q,      done_d;
  logic err_q,       err_d;

  logic              cmd_take;
  logic              cmd_bad;
  logic              load_start;
  logic              beat_hs;
  logic              beat_last;
  logic              line_last;
  logic [SUM_W-1:0]  end_line;

  // A command is seen only in IDLE; the range check is done two bits wider
  // than the address so base+lines can never wrap into a legal value.
  assign cmd_take   = (state_q == ST_IDLE) && cmd_valid;
  assign end_line   = SUM_W'(cmd_base) + SUM_W'(cmd_lines);
  assign cmd_bad    = (cmd_lines == '0) || (end_line > SUM_W'(MEM_DEPTH));
  assign load_start = cmd_take && !cmd_bad;
  assign beat_hs    = s_valid && s_ready_q;
  assign line_last  = (line_cnt_q == lines_q - LINES_W'(1));

  wmem_stream_loader_line_packer #(
    .IN_WIDTH (IN_WIDTH),
    .MAX_BPL  (MAX_BPL),
    .CNT_W    (CNT_W)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (load_start),
    .beat_i  (beat_hs),
    .data_i  (s_data),
    .bpl_i   (bpl_q),
    .line_o  (mem_in),
    .last_o  (beat_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state: fill a line, spend one cycle writing it, repeat until the
  // last line, then one FIN cycle for done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_start) state_d = ST_FILL;
      ST_FILL:  if (beat_hs && beat_last) state_d = ST_WRITE;
      ST_WRITE: state_d = line_last ? ST_FIN : ST_FILL;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output can be a register.
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    s_ready_d   = (state_d == ST_FILL);
    mem_en_d    = (state_d == ST_WRITE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
    err_d       = cmd_take && cmd_bad;
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready_q <= 1'b1;
      s_ready_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      s_ready_q   <= s_ready_d;
      mem_en_q    <= mem_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Command latch and line address: the address register always holds
  // base+line_cnt, stepping after each non-final write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q      <= '0;
      addr_q     <= '0;
      lines_q    <= '0;
      line_cnt_q <= '0;
      bpl_q      <= '0;
    end else if (cmd_take) begin
      sel_q      <= cmd_sel;
      addr_q     <= cmd_base;
      lines_q    <= cmd_lines;
      line_cnt_q <= '0;
      bpl_q      <= is_x_sel(cmd_sel) ? CNT_W'(X_BPL) : CNT_W'(MAX_BPL);
    end else if ((state_q == ST_WRITE) && !line_last) begin
      addr_q     <= addr_q + ADDR_W'(1);
      line_cnt_q <= line_cnt_q + LINES_W'(1);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign s_ready   = s_ready_q;
  assign mem_sel   = sel_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_en_q;
  assign mem_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
